// File: rtl/audio_ctrl_pkg.sv
// ============================================================================
// Module  : audio_ctrl_pkg
// Purpose : Shared types and constants for the audio record/playback controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_ctrl_pkg;

    localparam int c_ADDR_W = 20;
    localparam int c_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } state_e;

    // Playback address step indexed by the clamped speed code (1x, 2x, 4x, 8x)
    localparam logic [3:0][3:0] c_SPEED_STEP = {4'd8, 4'd4, 4'd2, 4'd1};

    function automatic logic [1:0] speed_idx(input logic [2:0] i_code);
        return (i_code > 3'd3) ? 2'd3 : i_code[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_access_seq.sv
// ============================================================================
// Module  : sram_access_seq
// Purpose : SRAM host-side sequencer: multi-cycle write strobe and the
//           read / capture / deliver pipeline for playback samples.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_access_seq
    import audio_ctrl_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int WR_CYCLES = 2
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_start,
    input  logic              i_rd_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_write_ram,
    output logic              o_read_ram,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic              o_wr_done
);

    localparam int                 c_CNT_W    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WR_CYCLES - 1);

    logic               r_write_ram;
    logic               r_read_ram;
    logic               r_rd_cap;
    logic               r_rd_valid;
    logic [c_CNT_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_ram <= 1'b0;
            r_read_ram  <= 1'b0;
            r_rd_cap    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_cnt    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
        end else begin
            if (i_wr_start) begin
                r_write_ram <= 1'b1;
                r_wdata     <= i_wdata;
                r_wr_cnt    <= c_CNT_LOAD;
            end else if (r_write_ram) begin
                if (r_wr_cnt == '0) begin
                    r_write_ram <= 1'b0;
                end else begin
                    r_wr_cnt <= r_wr_cnt - 1'b1;
                end
            end

            if (i_wr_start || i_rd_start) begin
                r_addr <= i_addr;
            end

            // SRAM returns data the cycle after ReadRAM; capture it at the end of that cycle
            r_read_ram <= i_rd_start;
            r_rd_cap   <= r_read_ram;
            r_rd_valid <= r_rd_cap;
            if (r_rd_cap) begin
                r_rd_data <= i_sram_rdata;
            end
        end
    end

    assign o_write_ram = r_write_ram;
    assign o_read_ram  = r_read_ram;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_busy      = r_write_ram | r_read_ram | r_rd_cap;
    assign o_wr_done   = r_write_ram && (r_wr_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/audio_rec_ctrl.sv
// ============================================================================
// Module  : audio_rec_ctrl
// Purpose : Record/playback controller in front of the SRAM host interface.
//           Optional variable playback speed when PLAY_SPEED_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_rec_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = c_ADDR_W,
    parameter int                DATA_W    = c_DATA_W,
    parameter int                WR_CYCLES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR  = {ADDR_W{1'b1}}
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rec,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_adc_valid,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_dac_req,
    input  logic [DATA_W-1:0] i_sram_rdata,
`ifdef PLAY_SPEED_EN
    input  logic [2:0]        i_speed,
`endif
    output logic              o_write_ram,
    output logic              o_read_ram,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_dac_valid,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_done,
    output logic              o_overrun
);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_end_addr, w_end_nxt;
    logic              r_overrun, w_ovr_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pend_stop, w_pstop_nxt;
    logic              r_pend_pause, w_ppause_nxt;
    logic              r_last, w_last_nxt;

    logic              w_wr_start;
    logic              w_rd_start;
    logic              w_busy;
    logic              w_wr_done;
    logic              w_rd_valid;

    logic              w_in_rec;
    logic              w_in_play;
    logic              w_finish;
    logic              w_stop_eff;
    logic              w_tog_eff;
    logic [ADDR_W:0]   w_addr_inc;
    logic [ADDR_W-1:0] w_end_sat;
    logic [ADDR_W:0]   w_step;
    logic [ADDR_W:0]   w_play_nxt;

`ifdef PLAY_SPEED_EN
    assign w_step = {{(ADDR_W-3){1'b0}}, c_SPEED_STEP[speed_idx(i_speed)]};
`else
    assign w_step = {{ADDR_W{1'b0}}, 1'b1};
`endif

    // Extra MSB keeps the length and playback-address arithmetic free of wrap-around
    assign w_addr_inc = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_end_sat  = w_addr_inc[ADDR_W] ? {ADDR_W{1'b1}} : w_addr_inc[ADDR_W-1:0];
    assign w_play_nxt = {1'b0, r_addr} + w_step;

    assign w_in_rec   = (r_state == ST_REC)  || (r_state == ST_REC_PAUSE);
    assign w_in_play  = (r_state == ST_PLAY) || (r_state == ST_PLAY_PAUSE);
    assign w_finish   = (w_in_rec && w_wr_done && (r_addr == MAX_ADDR)) ||
                        (w_in_play && w_rd_valid && r_last);
    assign w_stop_eff = i_stop | r_pend_stop;
    assign w_tog_eff  = ~i_stop & (i_pause ^ r_pend_pause);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_end_addr   <= '0;
            r_overrun    <= 1'b0;
            r_done       <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_pause <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_end_addr   <= w_end_nxt;
            r_overrun    <= w_ovr_nxt;
            r_done       <= w_done_nxt;
            r_pend_stop  <= w_pstop_nxt;
            r_pend_pause <= w_ppause_nxt;
            r_last       <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_end_nxt    = r_end_addr;
        w_ovr_nxt    = r_overrun;
        w_done_nxt   = 1'b0;
        w_pstop_nxt  = r_pend_stop;
        w_ppause_nxt = r_pend_pause;
        w_last_nxt   = r_last;
        w_wr_start   = 1'b0;
        w_rd_start   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_pstop_nxt  = 1'b0;
                w_ppause_nxt = 1'b0;
                if (!i_stop && !i_pause) begin
                    if (i_rec) begin
                        w_state_nxt = ST_REC;
                        w_addr_nxt  = '0;
                        w_end_nxt   = '0;
                        w_ovr_nxt   = 1'b0;
                    end else if (i_play && (r_end_addr != '0)) begin
                        w_state_nxt = ST_PLAY;
                        w_addr_nxt  = '0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end

            default: begin
                if (w_in_rec && w_wr_done) begin
                    w_addr_nxt = w_addr_inc[ADDR_W-1:0];
                    w_end_nxt  = w_end_sat;
                end

                if (!w_in_rec && !w_in_play) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_finish) begin
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    w_pstop_nxt  = 1'b0;
                    w_ppause_nxt = 1'b0;
                end else if (w_busy) begin
                    // Commands wait for the in-flight SRAM access; new samples are dropped
                    w_pstop_nxt  = r_pend_stop | i_stop;
                    w_ppause_nxt = r_pend_pause ^ (i_pause & ~i_stop);
                    if ((r_state == ST_REC) && i_adc_valid) begin
                        w_ovr_nxt = 1'b1;
                    end
                end else begin
                    w_pstop_nxt  = 1'b0;
                    w_ppause_nxt = 1'b0;
                    if (w_stop_eff) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_tog_eff) begin
                        case (r_state)
                            ST_REC:       w_state_nxt = ST_REC_PAUSE;
                            ST_REC_PAUSE: w_state_nxt = ST_REC;
                            ST_PLAY:      w_state_nxt = ST_PLAY_PAUSE;
                            default:      w_state_nxt = ST_PLAY;
                        endcase
                    end else if ((r_state == ST_REC) && i_adc_valid) begin
                        w_wr_start = 1'b1;
                    end else if ((r_state == ST_PLAY) && i_dac_req) begin
                        w_rd_start = 1'b1;
                        w_addr_nxt = w_play_nxt[ADDR_W-1:0];
                        w_last_nxt = (w_play_nxt >= {1'b0, r_end_addr});
                    end
                end
            end
        endcase
    end

    sram_access_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WR_CYCLES (WR_CYCLES)
    ) u_seq (
        .clk          (clk),
        .reset        (reset),
        .i_wr_start   (w_wr_start),
        .i_rd_start   (w_rd_start),
        .i_addr       (r_addr),
        .i_wdata      (i_adc_data),
        .i_sram_rdata (i_sram_rdata),
        .o_write_ram  (o_write_ram),
        .o_read_ram   (o_read_ram),
        .o_addr       (o_addr),
        .o_wdata      (o_wdata),
        .o_rd_data    (o_dac_data),
        .o_rd_valid   (w_rd_valid),
        .o_busy       (w_busy),
        .o_wr_done    (w_wr_done)
    );

    assign o_dac_valid = w_rd_valid;
    assign o_state     = r_state;
    assign o_end_addr  = r_end_addr;
    assign o_done      = r_done;
    assign o_overrun   = r_overrun;

endmodule

`default_nettype wire
